// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and small op-decoding helpers.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic isDivOp(input logic [1:0] code);
    return code[1];
  endfunction

  function automatic logic isSignedOp(input logic [1:0] code);
    return ~code[0];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: WIDTH-cycle shift-add multiply or restoring
// divide on operand magnitudes, followed by a one-cycle sign fix-up.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 isDiv_q, isDiv_d;
  logic                 negRes_q, negRes_d;
  logic                 negRem_q, negRem_d;
  logic                 div0_q, div0_d;

  logic                 aNeg, bNeg;
  logic [WIDTH-1:0]     aMag, bMag;
  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       divTrial;
  logic [2*WIDTH-1:0]   mulStep, divStep, prodFix;
  logic [WIDTH-1:0]     quoFix, remFix;

  assign aNeg = isSignedOp(op) & src_a[WIDTH-1];
  assign bNeg = isSignedOp(op) & src_b[WIDTH-1];
  assign aMag = aNeg ? -src_a : src_a;
  assign bMag = bNeg ? -src_b : src_b;

  // acc holds {partial product, remaining multiplier bits} when multiplying and
  // {partial remainder, remaining dividend / quotient bits} when dividing.
  assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mulStep  = acc_q[0] ? {mulSum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
  assign divTrial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign divStep  = divTrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prodFix = negRes_q ? -acc_q : acc_q;
  assign quoFix  = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      isDiv_q  <= 1'b0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      isDiv_q  <= isDiv_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      div0_q   <= div0_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    isDiv_d  = isDiv_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    div0_d   = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          isDiv_d = isDivOp(op);
          if (isDivOp(op) && (src_b == '0)) begin
            div0_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            div0_d   = 1'b0;
            cnt_d    = CNT_W'(WIDTH);
            negRes_d = aNeg ^ bNeg;
            state_d  = ST_RUN;
            if (isDivOp(op)) begin
              opnd_d   = bMag;
              acc_d    = {{WIDTH{1'b0}}, aMag};
              negRem_d = aNeg;
            end else begin
              opnd_d   = aMag;
              acc_d    = {{WIDTH{1'b0}}, bMag};
              negRem_d = 1'b0;
            end
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        acc_d = isDiv_q ? divStep : mulStep;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (isDiv_q) begin
          hi_d = remFix;
          lo_d = quoFix;
        end else begin
          hi_d = prodFix[2*WIDTH-1:WIDTH];
          lo_d = prodFix[WIDTH-1:0];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
